// File: rtl/vin_fpdlink_unpack_if.sv
// Link-side bundle for vin_fpdlink_unpack: deserialized words in, registered pixel/sync stream out.
interface vin_fpdlink_unpack_if #(
  parameter int PIXELS   = 2,
  parameter int OUT_BITS = 4
);
  logic [21*PIXELS-1:0]       din;
  logic                       din_lock;
  logic                       v_vsync;
  logic                       v_hsync;
  logic                       v_de;
  logic [OUT_BITS*PIXELS-1:0] v_pixel;
  logic                       locked;
  logic                       sync_err;

  modport master (
    output din, din_lock,
    input  v_vsync, v_hsync, v_de, v_pixel, locked, sync_err
  );

  modport slave (
    input  din, din_lock,
    output v_vsync, v_hsync, v_de, v_pixel, locked, sync_err
  );
endinterface

// File: rtl/vin_fpdlink_unpack.sv
// FPD-Link slot unpacker: RGB666 -> greyscale (luma or CFA phase), vsync masked until the link settles.
// Optional frame-geometry check enabled by defining VIN_SYNC_CHECK_EN.
module vin_fpdlink_unpack #(
  parameter int    PIXELS      = 2,
  parameter int    OUT_BITS    = 4,
  parameter int    SKIP_FRAMES = 5,
  parameter string COLORMODE   = "DES"
) (
  input logic                 clk,
  input logic                 rst_n,
  vin_fpdlink_unpack_if.slave bus
);
  localparam int         PW        = OUT_BITS * PIXELS;
  localparam bit         IS_MONO   = (COLORMODE == "MONO");
  localparam logic [3:0] SKIP_LAST = 4'(SKIP_FRAMES - 1);
  localparam logic [3:0] SKIP_FULL = 4'(SKIP_FRAMES);

  logic [21*PIXELS-1:0] din;
  logic [20:0]          sync_slot;
  logic                 hs, vs, de, hs_rise, vs_rise;

  logic          v_vsync_q, v_vsync_d, v_hsync_q, v_hsync_d, v_de_q, v_de_d;
  logic [PW-1:0] v_pixel_q, v_pixel_d;
  logic          vs_prev_q, vs_prev_d, locked_q, locked_d;
  logic [3:0]    skip_q, skip_d;
  logic [1:0]    cx_q, cx_d, cy_q, cy_d;
  logic          first_line_q, first_line_d;
  logic          mismatch;

  logic [20:0] slot;
  logic [5:0]  r, g, b, sel;
  logic [7:0]  sum;
  int          s;
  logic        unused_bits;

  assign din       = bus.din;
  assign sync_slot = din[21*(PIXELS-1) +: 21];
  assign hs        = sync_slot[4];
  assign vs        = sync_slot[5];
  assign de        = sync_slot[6];
  // Registered raw hs doubles as the edge-detector history for both sync and CFA paths
  assign hs_rise   = hs & ~v_hsync_q;
  assign vs_rise   = vs & ~vs_prev_q;

  always_comb begin
    v_pixel_d = '0;
    slot      = '0;
    r         = '0;
    g         = '0;
    b         = '0;
    sel       = '0;
    sum       = '0;
    s         = 0;
    for (int p = 0; p < PIXELS; p++) begin
      slot = din[21*p +: 21];
      r    = slot[19:14];
      g    = {slot[11:7], slot[20]};
      b    = {slot[3:0], slot[13:12]};
      sum  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
      s    = (int'(cx_q) + 3 - (p % 3)) % 3;
      sel  = (s == 0) ? r : ((s == 1) ? g : b);
      if (IS_MONO) v_pixel_d[OUT_BITS*p +: OUT_BITS] = sum[7 -: OUT_BITS];
      else         v_pixel_d[OUT_BITS*p +: OUT_BITS] = sel[5 -: OUT_BITS];
    end
  end

  always_comb begin
    cx_d         = cx_q;
    cy_d         = cy_q;
    first_line_d = first_line_q;
    if (hs_rise && vs) begin
      cy_d         = 2'd1;
      cx_d         = 2'd0;
      first_line_d = 1'b1;
    end else if (hs_rise && !vs && !first_line_q) begin
      cx_d = cy_q;
      cy_d = (cy_q == 2'd2) ? 2'd0 : cy_q + 2'd1;
    end else if (de) begin
      first_line_d = 1'b0;
      cx_d         = (cx_q == 2'd2) ? 2'd0 : cx_q + 2'd1;
    end
  end

`ifdef VIN_SYNC_CHECK_EN
  logic [15:0] line_cnt_q, line_cnt_d, prev_cnt_q, prev_cnt_d;
  logic        have_prev_q, have_prev_d, sync_err_q;

  always_comb begin
    line_cnt_d  = line_cnt_q;
    prev_cnt_d  = prev_cnt_q;
    have_prev_d = have_prev_q;
    mismatch    = 1'b0;
    if (vs_rise) line_cnt_d = '0;
    else if (de && !v_de_q && line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
    // The first completed frame after lock only seeds the reference count
    if (!locked_q) begin
      have_prev_d = 1'b0;
    end else if (vs_rise) begin
      mismatch    = have_prev_q && (line_cnt_q != prev_cnt_q);
      prev_cnt_d  = line_cnt_q;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q  <= '0;
      prev_cnt_q  <= '0;
      have_prev_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      line_cnt_q  <= line_cnt_d;
      prev_cnt_q  <= prev_cnt_d;
      have_prev_q <= have_prev_d;
      sync_err_q  <= mismatch & bus.din_lock;
    end
  end

  assign bus.sync_err = sync_err_q;
`else
  assign mismatch     = 1'b0;
  assign bus.sync_err = 1'b0;
`endif

  // Lock loss (including a geometry mismatch) outranks a coincident vsync edge
  always_comb begin
    locked_d = locked_q;
    skip_d   = skip_q;
    if (!bus.din_lock || mismatch) begin
      locked_d = 1'b0;
      skip_d   = '0;
    end else if (vs_rise && !locked_q) begin
      if (skip_q >= SKIP_LAST) begin
        locked_d = 1'b1;
        skip_d   = SKIP_FULL;
      end else begin
        skip_d = skip_q + 4'd1;
      end
    end
    v_vsync_d = vs & locked_q;
    v_hsync_d = hs;
    v_de_d    = de;
    vs_prev_d = vs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_vsync_q    <= 1'b0;
      v_hsync_q    <= 1'b0;
      v_de_q       <= 1'b0;
      v_pixel_q    <= '0;
      vs_prev_q    <= 1'b0;
      locked_q     <= 1'b0;
      skip_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      first_line_q <= 1'b0;
    end else begin
      v_vsync_q    <= v_vsync_d;
      v_hsync_q    <= v_hsync_d;
      v_de_q       <= v_de_d;
      v_pixel_q    <= v_pixel_d;
      vs_prev_q    <= vs_prev_d;
      locked_q     <= locked_d;
      skip_q       <= skip_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      first_line_q <= first_line_d;
    end
  end

  assign unused_bits = ^{din, sum, sel};

  assign bus.v_vsync = v_vsync_q;
  assign bus.v_hsync = v_hsync_q;
  assign bus.v_de    = v_de_q;
  assign bus.v_pixel = v_pixel_q;
  assign bus.locked  = locked_q;
endmodule
